stream_arb2: RTL and testbench
==============================

STREAM_ARB2 -- requirements
Module: stream_arb2

Interface
REQ-001 The block SHALL have one parameter: MAX_BURST, default 4, maximum consecutive transfers granted to one requester while the other is waiting; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in0_data  input  16  requester 0 payload, unsigned.
REQ-005 in0_data2  input  13  requester 0 payload, signed.
REQ-006 in0_valid  input  1  requester 0 offers a beat.
REQ-007 in0_ready  output  1  arbiter accepts the requester 0 beat.
REQ-008 in1_data, in1_data2, in1_valid, in1_ready SHALL mirror REQ-004..REQ-007 for requester 1.
REQ-009 out_data  output  16  registered payload, unsigned.
REQ-010 out_data2  output  13  registered payload, signed; copied bit-exact, no sign extension or truncation.
REQ-011 out_valid  output  1  registered beat available.
REQ-012 out_ready  input  1  sink accepts the beat.
REQ-013 out_sel  output  1  source index of the beat on out_data/out_data2; registered with the payload.

Function
REQ-014 Handshake: a transfer SHALL occur on any port in a cycle where valid and ready are both 1; sources hold valid and payload stable until accepted.
REQ-015 load = !out_valid || out_ready; the output register SHALL accept a new beat only when load = 1 (full throughput, one beat per cycle).
REQ-016 State: owner in {IDLE, OWN0, OWN1}, burst_cnt (4 bits), last (1 bit, index of the last-served requester).
REQ-017 Effective grant g SHALL be computed each cycle from registered state and current valids:
- owner = OWNx, inx_valid = 1, and (burst_cnt < MAX_BURST or other requester not valid) -> g = x.
- otherwise only one valid -> g = that requester.
- otherwise both valid -> g = !last.
- otherwise no grant.
REQ-018 ing_ready = load; the non-granted in*_ready SHALL be 0; both SHALL be 0 when there is no grant.
REQ-019 in*_ready SHALL depend combinationally only on out_ready, out_valid, in0_valid, in1_valid and registered state; never on payload.
REQ-020 On a transfer from requester g: out_data, out_data2 <= ing payload; out_sel <= g; out_valid <= 1; last <= g; owner <= OWNg.
REQ-021 burst_cnt on a transfer: g equal to the previous owner and burst_cnt < MAX_BURST -> burst_cnt + 1; otherwise (owner change, or cap reached with the other requester idle) -> 1. burst_cnt SHALL never exceed MAX_BURST.
REQ-022 Output side: load = 1 with no input transfer -> out_valid <= 0; out_valid = 1 and out_ready = 0 -> output registers hold.
REQ-023 No valid input in a cycle with load = 1 -> owner <= IDLE and burst_cnt <= 0; last is retained.
REQ-024 Back-pressure (load = 0) SHALL freeze owner, burst_cnt and last.
REQ-025 Latency: an accepted input beat SHALL appear on out_* in the following cycle; no beat is dropped, duplicated or reordered per requester.

Reset
REQ-026 While rst_n = 0: out_valid = 0, out_data = 0, out_data2 = 0, out_sel = 0, owner = IDLE, burst_cnt = 0, last = 1 (requester 0 wins the first tie); in0_ready and in1_ready = 0.
REQ-027 Reset asserted mid-burst SHALL discard the registered beat immediately; after release, arbitration restarts from the REQ-026 state.

Verification
REQ-028 Single source: in0 streams 6 beats (data 0x0001..0x0006, data2 -1..-6) with out_ready = 1 -> out delivers the beats in order with 1-cycle latency, out_sel = 0, in1_ready = 0 throughout.
REQ-029 Contention, MAX_BURST = 4: both valid continuously, out_ready = 1 -> out_sel sequence 0,0,0,0,1,1,1,1,0,... with no idle cycles.
REQ-030 Burst cap with no competitor: in0 alone for 10 beats, MAX_BURST = 4 -> all 10 granted back-to-back; burst_cnt wraps 4 -> 1.
REQ-031 Back-pressure: out_ready = 0 for 3 cycles with out_valid = 1 -> out_data, out_data2 and out_sel stable, both in*_ready = 0; on release, the next beat is accepted in the same cycle.
REQ-032 Signed extremes: in1_data2 = -4096 (0x1000), then 4095, in1_data = 0xFFFF -> out_data2 and out_data bit-exact.
REQ-033 Async reset mid-burst: rst_n pulsed low between edges during contention -> out_valid = 0 at once; on the first tie after release, requester 0 is served first.

Source files
------------

// File: rtl/stream_arb2.sv
// rtl/stream_arb2.sv - two-requester stream arbiter with burst cap and registered output
//
// Purpose: arbitrates two valid/ready requesters onto one registered output
// stage. The current owner keeps the output for up to MAX_BURST consecutive
// beats while the other side waits, or indefinitely while the other side is
// idle. Ties with no owner alternate, starting with requester 0 after reset.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in0_data/in0_data2/in0_valid    requester 0 beat (16-bit unsigned, 13-bit signed)
//   in0_ready                       requester 0 beat accepted this cycle
//   in1_*                           same for requester 1
//   out_data/out_data2/out_valid    registered output beat
//   out_ready                       sink accepts the output beat
//   out_sel                         source index of the registered beat

module stream_arb2 #(
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [15:0]        in0_data,
  input  logic signed [12:0] in0_data2,
  input  logic               in0_valid,
  output logic               in0_ready,
  input  logic [15:0]        in1_data,
  input  logic signed [12:0] in1_data2,
  input  logic               in1_valid,
  output logic               in1_ready,
  output logic [15:0]        out_data,
  output logic signed [12:0] out_data2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sel
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } owner_e;

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  owner_e             owner_q, owner_d;
  logic [3:0]         burst_cnt_q, burst_cnt_d;
  logic               last_q, last_d;
  logic [15:0]        out_data_q, out_data_d;
  logic signed [12:0] out_data2_q, out_data2_d;
  logic               out_valid_q, out_valid_d;
  logic               out_sel_q, out_sel_d;

  logic   gnt;
  logic   g;
  logic   below_cap;
  logic   load;
  logic   xfer;
  owner_e g_owner;

  // Grant decision uses only registered state and the two valids, so the
  // ready path never depends on payload.
  always_comb begin
    gnt       = 1'b0;
    g         = 1'b0;
    below_cap = (burst_cnt_q < MAX_B);
    if (owner_q == OWN0 && in0_valid && (below_cap || !in1_valid)) begin
      gnt = 1'b1;
      g   = 1'b0;
    end else if (owner_q == OWN1 && in1_valid && (below_cap || !in0_valid)) begin
      gnt = 1'b1;
      g   = 1'b1;
    end else if (in0_valid && !in1_valid) begin
      gnt = 1'b1;
      g   = 1'b0;
    end else if (!in0_valid && in1_valid) begin
      gnt = 1'b1;
      g   = 1'b1;
    end else if (in0_valid && in1_valid) begin
      gnt = 1'b1;
      g   = !last_q;
    end
  end

  assign load    = !out_valid_q || out_ready;
  assign xfer    = gnt && load;
  assign g_owner = g ? OWN1 : OWN0;

  // rst_n gating keeps both readies low for the whole reset window even
  // though the cleared output register makes load = 1.
  assign in0_ready = rst_n && xfer && !g;
  assign in1_ready = rst_n && xfer && g;

  always_comb begin
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    last_d      = last_q;
    out_data_d  = out_data_q;
    out_data2_d = out_data2_q;
    out_valid_d = out_valid_q;
    out_sel_d   = out_sel_q;
    if (load) begin
      if (xfer) begin
        out_data_d  = g ? in1_data : in0_data;
        out_data2_d = g ? in1_data2 : in0_data2;
        out_sel_d   = g;
        out_valid_d = 1'b1;
        last_d      = g;
        owner_d     = g_owner;
        // Continuing owner counts up; a new owner, or the cap reached with
        // the other side idle, restarts the burst at 1.
        if (owner_q == g_owner && below_cap) begin
          burst_cnt_d = burst_cnt_q + 4'd1;
        end else begin
          burst_cnt_d = 4'd1;
        end
      end else begin
        // With load = 1 any valid produces a transfer, so this is the
        // no-request case: drop the output beat and release ownership.
        out_valid_d = 1'b0;
        owner_d     = IDLE;
        burst_cnt_d = 4'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q     <= IDLE;
      burst_cnt_q <= 4'd0;
      last_q      <= 1'b1;
      out_data_q  <= 16'd0;
      out_data2_q <= 13'sd0;
      out_valid_q <= 1'b0;
      out_sel_q   <= 1'b0;
    end else begin
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      last_q      <= last_d;
      out_data_q  <= out_data_d;
      out_data2_q <= out_data2_d;
      out_valid_q <= out_valid_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_data2 = out_data2_q;
  assign out_valid = out_valid_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_arb2.sv
// tb/tb_stream_arb2.sv - directed self-checking bench for stream_arb2

module tb_stream_arb2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in0_data, in1_data, out_data;
  logic [12:0] in0_data2, in1_data2, out_data2;
  logic        in0_valid, in1_valid, in0_ready, in1_ready;
  logic        out_valid, out_ready, out_sel;

  int n_cmp = 0;
  int n_err = 0;

  stream_arb2 #(.MAX_BURST(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in0_data  (in0_data),
    .in0_data2 (in0_data2),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in1_data  (in1_data),
    .in1_data2 (in1_data2),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .out_data  (out_data),
    .out_data2 (out_data2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  bit [11:0]   seq;
  logic        es;
  logic [15:0] c0, c1;
  logic [12:0] d2;

  initial begin
    rst_n     = 1'b0;
    in0_valid = 1'b1;
    in1_valid = 1'b1;
    in0_data  = 16'h1111;
    in0_data2 = 13'h0111;
    in1_data  = 16'h2222;
    in1_data2 = 13'h0222;
    out_ready = 1'b1;
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_data2", 32'(out_data2), 32'd0);
    check("rst_out_sel",   32'(out_sel),   32'd0);
    check("rst_in0_ready", 32'(in0_ready), 32'd0);
    check("rst_in1_ready", 32'(in1_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Contention from reset state: 0,0,0,0,1,1,1,1,0,0,0,0
    seq = 12'b0000_1111_0000;
    c0  = 16'd0;
    c1  = 16'd0;
    for (int i = 0; i < 12; i++) begin
      es        = seq[11-i];
      in0_valid = 1'b1;
      in1_valid = 1'b1;
      in0_data  = 16'h0100 + c0;
      in0_data2 = 13'(c0);
      in1_data  = 16'h0200 + c1;
      in1_data2 = 13'h1000 | 13'(c1);
      #1;
      check("cont_in0_ready", 32'(in0_ready), 32'(!es));
      check("cont_in1_ready", 32'(in1_ready), 32'(es));
      step();
      check("cont_out_valid", 32'(out_valid), 32'd1);
      check("cont_out_sel",   32'(out_sel),   32'(es));
      check("cont_out_data",  32'(out_data),  es ? 32'(16'h0200 + c1) : 32'(16'h0100 + c0));
      if (es) c1 = c1 + 16'd1;
      else    c0 = c0 + 16'd1;
    end

    // Async reset between edges while both still contend
    in0_data  = 16'h0100 + c0;
    in0_data2 = 13'(c0);
    in1_data  = 16'h0200 + c1;
    in1_data2 = 13'h1000 | 13'(c1);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_data",  32'(out_data),  32'd0);
    check("arst_in0_ready", 32'(in0_ready), 32'd0);
    check("arst_in1_ready", 32'(in1_ready), 32'd0);
    #2;
    rst_n = 1'b1;
    #1;
    check("arst_tie_in0_ready", 32'(in0_ready), 32'd1);
    check("arst_tie_in1_ready", 32'(in1_ready), 32'd0);
    step();
    check("arst_tie_sel",  32'(out_sel),  32'd0);
    check("arst_tie_data", 32'(out_data), 32'(16'h0100 + c0));
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    step();
    check("idle_out_valid", 32'(out_valid), 32'd0);

    // Single source, 10 back-to-back beats through the burst cap
    for (int i = 1; i <= 10; i++) begin
      in0_valid = 1'b1;
      in0_data  = 16'(i);
      d2        = 13'd0 - 13'(i);
      in0_data2 = d2;
      #1;
      check("solo_in0_ready", 32'(in0_ready), 32'd1);
      check("solo_in1_ready", 32'(in1_ready), 32'd0);
      step();
      check("solo_out_valid", 32'(out_valid), 32'd1);
      check("solo_out_data",  32'(out_data),  32'(i));
      check("solo_out_data2", 32'(out_data2), 32'(d2));
      check("solo_out_sel",   32'(out_sel),   32'd0);
    end
    in0_valid = 1'b0;
    step();
    check("solo_drain_valid", 32'(out_valid), 32'd0);

    // Back-pressure: hold for 3 cycles, accept same cycle as release
    in0_valid = 1'b1;
    in0_data  = 16'hA5A5;
    in0_data2 = 13'h0ABC;
    out_ready = 1'b1;
    step();
    check("bp_first_data", 32'(out_data), 32'hA5A5);
    in0_data  = 16'h5A5A;
    in0_data2 = 13'h1234;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in0_ready", 32'(in0_ready), 32'd0);
      check("bp_in1_ready", 32'(in1_ready), 32'd0);
      step();
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_data",  32'(out_data),  32'hA5A5);
      check("bp_out_data2", 32'(out_data2), 32'h0ABC);
      check("bp_out_sel",   32'(out_sel),   32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in0_ready), 32'd1);
    step();
    check("bp_release_data",  32'(out_data),  32'h5A5A);
    check("bp_release_data2", 32'(out_data2), 32'h1234);
    in0_valid = 1'b0;
    step();

    // Signed extremes on requester 1
    in1_valid = 1'b1;
    in1_data  = 16'hFFFF;
    in1_data2 = 13'h1000;
    #1;
    check("ext_in1_ready", 32'(in1_ready), 32'd1);
    check("ext_in0_ready", 32'(in0_ready), 32'd0);
    step();
    check("ext_min_data2", 32'(out_data2), 32'h1000);
    check("ext_min_data",  32'(out_data),  32'hFFFF);
    check("ext_min_sel",   32'(out_sel),   32'd1);
    in1_data2 = 13'h0FFF;
    step();
    check("ext_max_data2", 32'(out_data2), 32'h0FFF);
    check("ext_max_data",  32'(out_data),  32'hFFFF);
    in1_valid = 1'b0;
    step();
    check("ext_drain_valid", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
